id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the 5-stage RV32 core. It captures decode-stage operands and control into the E stage and produces the E-stage register addresses that the forwarding unit compares against M and W. It also contains the load-use hazard detector, which stalls F/D and inserts a bubble. It applies branch/jump flush and downstream hold.

---
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold.
// Optional perf counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN      = 32,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid_d,
  input  logic [XLEN-1:0]      i_pc_d,
  input  logic [XLEN-1:0]      i_pcplus4_d,
  input  logic [XLEN-1:0]      i_rd1_d,
  input  logic [XLEN-1:0]      i_rd2_d,
  input  logic [XLEN-1:0]      i_imm_d,
  input  logic [4:0]           i_rs1_addr_d,
  input  logic [4:0]           i_rs2_addr_d,
  input  logic [4:0]           i_rd_addr_d,
  input  logic                 i_use_rs1_d,
  input  logic                 i_use_rs2_d,
  input  logic                 i_regwrite_d,
  input  logic                 i_memwrite_d,
  input  logic                 i_memread_d,
  input  logic [1:0]           i_resultsrc_d,
  input  logic [ALUCTRL_W-1:0] i_alucontrol_d,
  input  logic                 i_alusrc_d,
  input  logic                 i_branch_d,
  input  logic                 i_jump_d,
  input  logic                 i_flush_e,
  input  logic                 i_stall_e,
  output logic                 o_stall_fd,
  output logic                 o_valid_e,
  output logic [XLEN-1:0]      o_pc_e,
  output logic [XLEN-1:0]      o_pcplus4_e,
  output logic [XLEN-1:0]      o_rd1_e,
  output logic [XLEN-1:0]      o_rd2_e,
  output logic [XLEN-1:0]      o_imm_e,
  output logic [4:0]           o_rs1_addr_e,
  output logic [4:0]           o_rs2_addr_e,
  output logic [4:0]           o_rd_addr_e,
  output logic                 o_regwrite_e,
  output logic                 o_memwrite_e,
  output logic                 o_memread_e,
  output logic [1:0]           o_resultsrc_e,
  output logic [ALUCTRL_W-1:0] o_alucontrol_e,
  output logic                 o_alusrc_e,
  output logic                 o_branch_e,
  output logic                 o_jump_e
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [15:0]          o_loaduse_cnt,
  output logic [15:0]          o_flush_cnt
`endif
);

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pcplus4;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      imm;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [4:0]           rd_addr;
    logic                 regwrite;
    logic                 memwrite;
    logic                 memread;
    logic [1:0]           resultsrc;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic                 alusrc;
    logic                 branch;
    logic                 jump;
  } e_t;

  e_t e_q;
  e_t e_d;
  e_t d_cap;

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  // An invalid D slot is captured as a full bubble so nothing downstream acts on it.
  always_comb begin
    d_cap = '0;
    if (i_valid_d) begin
      d_cap.valid      = 1'b1;
      d_cap.pc         = i_pc_d;
      d_cap.pcplus4    = i_pcplus4_d;
      d_cap.rd1        = i_rd1_d;
      d_cap.rd2        = i_rd2_d;
      d_cap.imm        = i_imm_d;
      d_cap.rs1_addr   = i_rs1_addr_d;
      d_cap.rs2_addr   = i_rs2_addr_d;
      d_cap.rd_addr    = i_rd_addr_d;
      d_cap.regwrite   = i_regwrite_d;
      d_cap.memwrite   = i_memwrite_d;
      d_cap.memread    = i_memread_d;
      d_cap.resultsrc  = i_resultsrc_d;
      d_cap.alucontrol = i_alucontrol_d;
      d_cap.alusrc     = i_alusrc_d;
      d_cap.branch     = i_branch_d;
      d_cap.jump       = i_jump_d;
    end
  end

  assign rs1_hit = i_use_rs1_d
                 & (e_q.rd_addr == i_rs1_addr_d);
  assign rs2_hit = i_use_rs2_d
                 & (e_q.rd_addr == i_rs2_addr_d);

  assign load_use = e_q.valid
                  & e_q.memread
                  & (e_q.rd_addr != 5'd0)
                  & i_valid_d
                  & (rs1_hit | rs2_hit);

  assign o_stall_fd = ~i_flush_e
                    & (load_use | i_stall_e);

  // Flush beats hold, hold beats load-use bubble.
  always_comb begin
    e_d = e_q;
    priority case (1'b1)
      i_flush_e: e_d = '0;
      i_stall_e: e_d = e_q;
      load_use:  e_d = '0;
      default:   e_d = d_cap;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  assign o_valid_e      = e_q.valid;
  assign o_pc_e         = e_q.pc;
  assign o_pcplus4_e    = e_q.pcplus4;
  assign o_rd1_e        = e_q.rd1;
  assign o_rd2_e        = e_q.rd2;
  assign o_imm_e        = e_q.imm;
  assign o_rs1_addr_e   = e_q.rs1_addr;
  assign o_rs2_addr_e   = e_q.rs2_addr;
  assign o_rd_addr_e    = e_q.rd_addr;
  assign o_regwrite_e   = e_q.regwrite;
  assign o_memwrite_e   = e_q.memwrite;
  assign o_memread_e    = e_q.memread;
  assign o_resultsrc_e  = e_q.resultsrc;
  assign o_alucontrol_e = e_q.alucontrol;
  assign o_alusrc_e     = e_q.alusrc;
  assign o_branch_e     = e_q.branch;
  assign o_jump_e       = e_q.jump;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] lu_cnt_q;
  logic [15:0] fl_cnt_q;
  logic        lu_bubble;

  assign lu_bubble = ~i_flush_e
                   & ~i_stall_e
                   & load_use;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      if (lu_bubble && lu_cnt_q != 16'hFFFF)
        lu_cnt_q <= lu_cnt_q + 16'd1;
      if (i_flush_e && fl_cnt_q != 16'hFFFF)
        fl_cnt_q <= fl_cnt_q + 16'd1;
    end
  end

  assign o_loaduse_cnt = lu_cnt_q;
  assign o_flush_cnt   = fl_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage against a behavioural E-slot model.
// Counter checks compile in when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use1;
    logic        use2;
    logic        regwrite;
    logic        memwrite;
    logic        memread;
    logic [1:0]  resultsrc;
    logic [3:0]  aluctrl;
    logic        alusrc;
    logic        branch;
    logic        jump;
  } ins_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid_d;
  logic [31:0] i_pc_d, i_pcplus4_d, i_rd1_d, i_rd2_d, i_imm_d;
  logic [4:0]  i_rs1_addr_d, i_rs2_addr_d, i_rd_addr_d;
  logic        i_use_rs1_d, i_use_rs2_d;
  logic        i_regwrite_d, i_memwrite_d, i_memread_d;
  logic [1:0]  i_resultsrc_d;
  logic [3:0]  i_alucontrol_d;
  logic        i_alusrc_d, i_branch_d, i_jump_d;
  logic        i_flush_e, i_stall_e;
  logic        o_stall_fd, o_valid_e;
  logic [31:0] o_pc_e, o_pcplus4_e, o_rd1_e, o_rd2_e, o_imm_e;
  logic [4:0]  o_rs1_addr_e, o_rs2_addr_e, o_rd_addr_e;
  logic        o_regwrite_e, o_memwrite_e, o_memread_e;
  logic [1:0]  o_resultsrc_e;
  logic [3:0]  o_alucontrol_e;
  logic        o_alusrc_e, o_branch_e, o_jump_e;
`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] o_loaduse_cnt, o_flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  ins_t d_cur;
  ins_t exp_e;
  int   exp_lu_cnt;
  int   exp_fl_cnt;

  always #5 i_clk = ~i_clk;

  id_ex_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid_d(i_valid_d), .i_pc_d(i_pc_d),
    .i_pcplus4_d(i_pcplus4_d), .i_rd1_d(i_rd1_d),
    .i_rd2_d(i_rd2_d), .i_imm_d(i_imm_d),
    .i_rs1_addr_d(i_rs1_addr_d), .i_rs2_addr_d(i_rs2_addr_d),
    .i_rd_addr_d(i_rd_addr_d), .i_use_rs1_d(i_use_rs1_d),
    .i_use_rs2_d(i_use_rs2_d), .i_regwrite_d(i_regwrite_d),
    .i_memwrite_d(i_memwrite_d), .i_memread_d(i_memread_d),
    .i_resultsrc_d(i_resultsrc_d), .i_alucontrol_d(i_alucontrol_d),
    .i_alusrc_d(i_alusrc_d), .i_branch_d(i_branch_d),
    .i_jump_d(i_jump_d), .i_flush_e(i_flush_e),
    .i_stall_e(i_stall_e), .o_stall_fd(o_stall_fd),
    .o_valid_e(o_valid_e), .o_pc_e(o_pc_e),
    .o_pcplus4_e(o_pcplus4_e), .o_rd1_e(o_rd1_e),
    .o_rd2_e(o_rd2_e), .o_imm_e(o_imm_e),
    .o_rs1_addr_e(o_rs1_addr_e), .o_rs2_addr_e(o_rs2_addr_e),
    .o_rd_addr_e(o_rd_addr_e), .o_regwrite_e(o_regwrite_e),
    .o_memwrite_e(o_memwrite_e), .o_memread_e(o_memread_e),
    .o_resultsrc_e(o_resultsrc_e), .o_alucontrol_e(o_alucontrol_e),
    .o_alusrc_e(o_alusrc_e), .o_branch_e(o_branch_e),
    .o_jump_e(o_jump_e)
`ifdef ID_EX_PERF_CNT_EN
    , .o_loaduse_cnt(o_loaduse_cnt), .o_flush_cnt(o_flush_cnt)
`endif
  );

  function automatic ins_t obs();
    ins_t x;
    x = '0;
    x.valid = o_valid_e; x.pc = o_pc_e; x.pcp4 = o_pcplus4_e;
    x.rd1 = o_rd1_e; x.rd2 = o_rd2_e; x.imm = o_imm_e;
    x.rs1 = o_rs1_addr_e; x.rs2 = o_rs2_addr_e; x.rd = o_rd_addr_e;
    x.regwrite = o_regwrite_e; x.memwrite = o_memwrite_e;
    x.memread = o_memread_e; x.resultsrc = o_resultsrc_e;
    x.aluctrl = o_alucontrol_e; x.alusrc = o_alusrc_e;
    x.branch = o_branch_e; x.jump = o_jump_e;
    return x;
  endfunction

  function automatic ins_t rand_ins();
    ins_t x;
    x.valid = ($urandom_range(0, 7) != 0);
    x.pc = $urandom; x.pcp4 = $urandom;
    x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom;
    x.rs1 = 5'($urandom_range(0, 3));
    x.rs2 = 5'($urandom_range(0, 3));
    x.rd  = 5'($urandom_range(0, 3));
    x.use1 = 1'($urandom); x.use2 = 1'($urandom);
    x.regwrite = 1'($urandom); x.memwrite = 1'($urandom);
    x.memread = 1'($urandom); x.resultsrc = 2'($urandom);
    x.aluctrl = 4'($urandom); x.alusrc = 1'($urandom);
    x.branch = 1'($urandom); x.jump = 1'($urandom);
    return x;
  endfunction

  task automatic drive(input ins_t x);
    d_cur = x;
    i_valid_d = x.valid; i_pc_d = x.pc; i_pcplus4_d = x.pcp4;
    i_rd1_d = x.rd1; i_rd2_d = x.rd2; i_imm_d = x.imm;
    i_rs1_addr_d = x.rs1; i_rs2_addr_d = x.rs2; i_rd_addr_d = x.rd;
    i_use_rs1_d = x.use1; i_use_rs2_d = x.use2;
    i_regwrite_d = x.regwrite; i_memwrite_d = x.memwrite;
    i_memread_d = x.memread; i_resultsrc_d = x.resultsrc;
    i_alucontrol_d = x.aluctrl; i_alusrc_d = x.alusrc;
    i_branch_d = x.branch; i_jump_d = x.jump;
  endtask

  // A load in E whose nonzero rd is read by a valid D instruction.
  function automatic logic model_lu();
    logic hit;
    hit = (d_cur.use1 && d_cur.rs1 == exp_e.rd)
       || (d_cur.use2 && d_cur.rs2 == exp_e.rd);
    return exp_e.valid && exp_e.memread && exp_e.rd != 0
        && d_cur.valid && hit;
  endfunction

  function automatic logic model_stall();
    return !i_flush_e && (model_lu() || i_stall_e);
  endfunction

  // Advance one clock and move the model the way the E slot should move.
  task automatic step();
    ins_t nxt;
    nxt = d_cur;
    nxt.use1 = 1'b0;
    nxt.use2 = 1'b0;
    if (!d_cur.valid) nxt = '0;
    @(posedge i_clk);
    if (i_flush_e) begin
      exp_e = '0;
      if (exp_fl_cnt < 65535) exp_fl_cnt++;
    end else if (i_stall_e) begin
      exp_e = exp_e;
    end else if (model_lu()) begin
      exp_e = '0;
      if (exp_lu_cnt < 65535) exp_lu_cnt++;
    end else begin
      exp_e = nxt;
    end
    #1;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    exp_e = '0;
    exp_lu_cnt = 0;
    exp_fl_cnt = 0;
    #1;
  endtask

  task automatic test_reset();
    ins_t x;
    i_flush_e = 1'b0;
    i_stall_e = 1'b0;
    x = rand_ins();
    x.valid = 1'b1;
    x.pc = 32'h0000_1234;
    drive(x);
    i_rst_n = 1'b1;
    step();
    @(negedge i_clk);
    #2;
    apply_reset();
    vectors++;
    if (obs() !== ins_t'(0)) begin
      miscompares++;
      $display("FAIL reset_e got %h exp 0", obs());
    end
    vectors++;
    if (o_stall_fd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall got %b exp 0", o_stall_fd);
    end
`ifdef ID_EX_PERF_CNT_EN
    vectors++;
    if (o_flush_cnt !== 16'd0 || o_loaduse_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0",
               o_flush_cnt, o_loaduse_cnt);
    end
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    vectors++;
    if (o_valid_e !== 1'b1 || o_pc_e !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL reset_first_cap got %b/%h exp 1/00001234",
               o_valid_e, o_pc_e);
    end
  endtask

  task automatic test_load_use();
    ins_t lw, dep;
    lw = rand_ins();
    lw.valid = 1'b1; lw.memread = 1'b1; lw.rd = 5'd5;
    drive(lw);
    step();
    dep = rand_ins();
    dep.valid = 1'b1; dep.use1 = 1'b1; dep.rs1 = 5'd5;
    dep.use2 = 1'b0;
    drive(dep);
    #1;
    vectors++;
    if (o_stall_fd !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_stall got %b exp 1", o_stall_fd);
    end
    step();
    vectors++;
    if (o_rd_addr_e !== 5'd0 || o_regwrite_e !== 1'b0
        || o_valid_e !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_bubble got rd=%0d rw=%b v=%b exp 0/0/0",
               o_rd_addr_e, o_regwrite_e, o_valid_e);
    end
    vectors++;
    if (o_stall_fd !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_release got %b exp 0", o_stall_fd);
    end
    step();
    vectors++;
    if (o_pc_e !== dep.pc || o_rs1_addr_e !== 5'd5) begin
      miscompares++;
      $display("FAIL lu_capture got %h/%0d exp %h/5",
               o_pc_e, o_rs1_addr_e, dep.pc);
    end
  endtask

  task automatic test_no_false_stall();
    ins_t lw, d;
    lw = rand_ins();
    lw.valid = 1'b1; lw.memread = 1'b1; lw.rd = 5'd0;
    drive(lw);
    step();
    d = rand_ins();
    d.valid = 1'b1; d.use1 = 1'b1; d.rs1 = 5'd0;
    drive(d);
    #1;
    vectors++;
    if (o_stall_fd !== 1'b0) begin
      miscompares++;
      $display("FAIL nfs_x0 got %b exp 0", o_stall_fd);
    end
    lw.rd = 5'd5;
    drive(lw);
    step();
    step();
    d = rand_ins();
    d.valid = 1'b1; d.use1 = 1'b0; d.use2 = 1'b0;
    d.rs1 = 5'd5; d.rs2 = 5'd5;
    drive(d);
    #1;
    vectors++;
    if (o_stall_fd !== 1'b0) begin
      miscompares++;
      $display("FAIL nfs_unused got %b exp 0", o_stall_fd);
    end
    step();
    vectors++;
    if (o_pc_e !== d.pc || o_valid_e !== 1'b1) begin
      miscompares++;
      $display("FAIL nfs_capture got %h exp %h", o_pc_e, d.pc);
    end
  endtask

  task automatic test_invalid_d();
    ins_t d;
    d = rand_ins();
    d.valid = 1'b0; d.rd = 5'd7; d.regwrite = 1'b1;
    d.memwrite = 1'b1; d.jump = 1'b1;
    drive(d);
    step();
    vectors++;
    if (o_valid_e !== 1'b0 || o_rd_addr_e !== 5'd0
        || o_regwrite_e !== 1'b0 || o_memwrite_e !== 1'b0
        || o_jump_e !== 1'b0 || o_rs1_addr_e !== 5'd0) begin
      miscompares++;
      $display("FAIL invalid_d got v=%b rd=%0d rw=%b mw=%b exp zeros",
               o_valid_e, o_rd_addr_e, o_regwrite_e, o_memwrite_e);
    end
  endtask

  task automatic test_flush_priority();
    ins_t lw, dep;
    int fl0, lu0;
    lw = rand_ins();
    lw.valid = 1'b1; lw.memread = 1'b1; lw.rd = 5'd9;
    drive(lw);
    step();
    dep = rand_ins();
    dep.valid = 1'b1; dep.use2 = 1'b1; dep.rs2 = 5'd9;
    drive(dep);
    i_flush_e = 1'b1;
    #1;
    vectors++;
    if (o_stall_fd !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_lu_stall got %b exp 0", o_stall_fd);
    end
`ifdef ID_EX_PERF_CNT_EN
    fl0 = int'(o_flush_cnt);
    lu0 = int'(o_loaduse_cnt);
`else
    fl0 = 0;
    lu0 = 0;
`endif
    step();
    vectors++;
    if (obs() !== ins_t'(0)) begin
      miscompares++;
      $display("FAIL flush_lu_bubble got %h exp 0", obs());
    end
`ifdef ID_EX_PERF_CNT_EN
    vectors++;
    if (int'(o_flush_cnt) != fl0 + 1 || int'(o_loaduse_cnt) != lu0) begin
      miscompares++;
      $display("FAIL flush_lu_cnt got %0d/%0d exp %0d/%0d",
               o_flush_cnt, o_loaduse_cnt, fl0 + 1, lu0);
    end
`endif
    i_flush_e = 1'b0;
    step();
    i_stall_e = 1'b1;
    i_flush_e = 1'b1;
    #1;
    vectors++;
    if (o_stall_fd !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_hold_stall got %b exp 0", o_stall_fd);
    end
    step();
    vectors++;
    if (obs() !== ins_t'(0)) begin
      miscompares++;
      $display("FAIL flush_hold_bubble got %h exp 0", obs());
    end
    i_stall_e = 1'b0;
    i_flush_e = 1'b0;
  endtask

  task automatic test_hold();
    ins_t a, b;
    ins_t held;
    a = rand_ins();
    a.valid = 1'b1; a.memread = 1'b0;
    drive(a);
    step();
    held = obs();
    b = rand_ins();
    b.valid = 1'b1;
    drive(b);
    i_stall_e = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (o_stall_fd !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_stall[%0d] got %b exp 1", k, o_stall_fd);
      end
      step();
      vectors++;
      if (obs() !== exp_e || o_pc_e !== a.pc) begin
        miscompares++;
        $display("FAIL hold_keep[%0d] got %h exp %h", k, obs(), held);
      end
    end
    i_stall_e = 1'b0;
    step();
    vectors++;
    if (o_pc_e !== b.pc || o_valid_e !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release got %h exp %h", o_pc_e, b.pc);
    end
  endtask

  task automatic test_async_reset_hold();
    ins_t a;
    a = rand_ins();
    a.valid = 1'b1;
    drive(a);
    step();
    i_stall_e = 1'b1;
    i_flush_e = 1'b0;
    #2;
    apply_reset();
    vectors++;
    if (obs() !== ins_t'(0)) begin
      miscompares++;
      $display("FAIL arst_hold got %h exp 0", obs());
    end
    i_stall_e = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      drive(rand_ins());
      i_flush_e = ($urandom_range(0, 15) == 0);
      i_stall_e = ($urandom_range(0, 7) == 0);
      #1;
      vectors++;
      if (o_stall_fd !== model_stall()) begin
        miscompares++;
        $display("FAIL rand_stall[%0d] got %b exp %b",
                 n, o_stall_fd, model_stall());
      end
      step();
      vectors++;
      if (obs() !== exp_e) begin
        miscompares++;
        $display("FAIL rand_e[%0d] got %h exp %h", n, obs(), exp_e);
      end
`ifdef ID_EX_PERF_CNT_EN
      vectors++;
      if (int'(o_flush_cnt) != exp_fl_cnt
          || int'(o_loaduse_cnt) != exp_lu_cnt) begin
        miscompares++;
        $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", n,
                 o_flush_cnt, o_loaduse_cnt, exp_fl_cnt, exp_lu_cnt);
      end
`endif
    end
    i_flush_e = 1'b0;
    i_stall_e = 1'b0;
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_saturation();
    i_flush_e = 1'b1;
    for (int n = 0; n < 65537; n++) step();
    vectors++;
    if (o_flush_cnt !== 16'hFFFF || exp_fl_cnt != 65535) begin
      miscompares++;
      $display("FAIL flush_sat got %h exp ffff", o_flush_cnt);
    end
    i_flush_e = 1'b0;
  endtask
`endif

  initial begin
    d_cur = '0;
    drive('0);
    i_flush_e = 1'b0;
    i_stall_e = 1'b0;
    apply_reset();
    repeat (2) @(negedge i_clk);
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_invalid_d();
    test_flush_priority();
    test_hold();
    test_async_reset_hold();
    test_random();
`ifdef ID_EX_PERF_CNT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
